dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/load_extend.sv | 33 +++
 rtl/dmem_access_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 data-memory definitions: funct3 size encodings, access FSM states,
// and the lane/enable helpers used when a request is launched onto the bus.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_e;

    // funct3[1:0] carries the size; the unsigned bit does not affect alignment.
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~lane[0];
            2'b10:   return (lane == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f3_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f3_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a bus read word and sign- or
// zero-extends it according to the load size.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: launches one registered bus request
// per valid load/store, stalls the pipeline until ack or timeout, and faults bad requests.
module dmem_access_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    dmem_state_e state_q, state_d;
    logic [7:0]  cnt_q;
    logic        fault_q;
    logic        bus_req_q, bus_we_q;
    logic [31:0] bus_addr_q, bus_wdata_q, rdata_q;
    logic [3:0]  bus_be_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [31:0] ext_data;

    logic one_req, req_ok, req_bad, timeout_hit;

    assign one_req     = mem_rd_en ^ mem_wr_en;
    assign req_ok      = one_req & f3_aligned(mem_funct3, mem_addr[1:0]);
    assign req_bad     = (mem_rd_en & mem_wr_en) | (one_req & ~req_ok);
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    load_extend u_load_extend (
        .word_i   (bus_rdata),
        .lane_i   (lane_q),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_ok) state_d = ST_ACCESS;
            ST_ACCESS: if (bus_ack || timeout_hit) state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rdata_q     <= '0;
            lane_q      <= '0;
            funct3_q    <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    fault_q <= req_bad;
                    if (req_ok) begin
                        cnt_q       <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_wr_en;
                        bus_addr_q  <= {mem_addr[31:2], 2'b00};
                        bus_be_q    <= f3_be(mem_funct3, mem_addr[1:0]);
                        bus_wdata_q <= mem_wr_en ? f3_wdata(mem_funct3, mem_wdata) : '0;
                        lane_q      <= mem_addr[1:0];
                        funct3_q    <= mem_funct3;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A late ack on the timeout edge still wins over the fault.
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        rdata_q   <= bus_we_q ? '0 : ext_data;
                    end else if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        rdata_q   <= '0;
                        fault_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset gates the combinational stall so every output is low while RST is asserted.
    assign stall        = RST & (((state_q == ST_IDLE) & req_ok) | (state_q == ST_ACCESS));
    assign mem_rdata    = rdata_q;
    assign access_fault = fault_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_be       = bus_be_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a transaction-level timeline model drives
// per-cycle expectations checked at every falling edge, plus literal spot checks.
module tb_dmem_access_ctrl;
    import riscv_pkg::*;

    localparam int unsigned TO = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [2:0]  mem_funct3 = '0;
    logic [31:0] mem_rdata;
    logic        stall, access_fault, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .stall(stall), .access_fault(access_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic        chk_en = 1'b0;
    logic        e_stall = 1'b0, e_req = 1'b0, e_fault = 1'b0, e_we = 1'b0, e_resp = 1'b0;
    logic [31:0] e_rdata = '0, e_addr = '0, e_wdata = '0;
    logic [3:0]  e_be = '0;

    int          cap_stall, cap_req;
    logic        cap_fault, cap_we;
    logic [31:0] cap_rdata, cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the access rules.
    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b11) return 1'b0;
        return (int'(a[1:0]) % m_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_bytes(f3)) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_bytes(f3) == 1) return wd[7:0] * 32'h0101_0101;
        if (m_bytes(f3) == 2) return wd[15:0] * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * int'(a[1:0]));
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'h0, s[7:0]};
            F3_HU:   return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check1("stall", stall, e_stall);
            check1("bus_req", bus_req, e_req);
            check1("access_fault", access_fault, e_fault);
            check1("bus_we", bus_we, e_we);
            if (e_req) begin
                check32("bus_addr", bus_addr, e_addr);
                check32("bus_be", {28'h0, bus_be}, {28'h0, e_be});
                if (e_we) check32("bus_wdata", bus_wdata, e_wdata);
            end
            if (e_resp) check32("mem_rdata", mem_rdata, e_rdata);
        end
    end

    task automatic sample();
        @(negedge CLK);
        if (stall)   cap_stall++;
        if (bus_req) cap_req++;
    endtask

    // ack_at: ACCESS cycle (0-based) in which bus_ack is raised; >= TO means never.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rword);
        logic valid, to;
        int   n;
        cap_stall = 0; cap_req = 0; cap_fault = 1'b0; cap_we = 1'b0;
        cap_rdata = '0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
        valid = (rd ^ wr) && m_aligned(f3, addr);
        to    = (ack_at >= int'(TO));
        n     = to ? int'(TO) : ack_at + 1;

        @(posedge CLK); #1;
        mem_rd_en = rd; mem_wr_en = wr; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
        bus_rdata = rword; bus_ack = 1'b1;
        e_stall = valid; e_req = 1'b0; e_fault = 1'b0; e_we = 1'b0; e_resp = 1'b0;
        e_addr  = {addr[31:2], 2'b00};
        e_be    = m_be(f3, addr);
        e_wdata = m_wdata(f3, wd);
        sample();

        if (!valid) begin
            @(posedge CLK); #1;
            mem_rd_en = 1'b0; mem_wr_en = 1'b0; bus_ack = 1'b0;
            e_stall = 1'b0; e_fault = 1'b1;
            sample();
            cap_fault = access_fault;
            @(posedge CLK); #1;
            e_fault = 1'b0;
            sample();
            return;
        end

        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
            bus_ack = (c == ack_at);
            e_req = 1'b1; e_stall = 1'b1; e_we = wr;
            sample();
            if (c == 0) begin
                cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be;
            end
        end

        // RESP: request and ack are both left asserted; neither may restart anything.
        @(posedge CLK); #1;
        bus_ack = 1'b1;
        e_req = 1'b0; e_stall = 1'b0; e_we = 1'b0; e_fault = to;
        e_resp  = rd;
        e_rdata = to ? 32'h0 : m_load(f3, addr, rword);
        sample();
        cap_rdata = mem_rdata; cap_fault = access_fault;

        @(posedge CLK); #1;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; bus_ack = 1'b0;
        e_resp = 1'b0; e_fault = 1'b0;
        sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a valid load already presented: everything must stay low.
        mem_rd_en = 1'b1; mem_addr = 32'h10; mem_funct3 = F3_W;
        #2;
        check1("rst_stall", stall, 1'b0);
        check1("rst_req", bus_req, 1'b0);
        check1("rst_fault", access_fault, 1'b0);
        check32("rst_rdata", mem_rdata, 32'h0);
        check32("rst_addr", bus_addr, 32'h0);
        mem_rd_en = 1'b0;
        #10;
        RST = 1'b1;
        chk_en = 1'b1;

        run(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
        check32("lw_stall_cycles", 32'(cap_stall), 32'd2);
        check32("lw_bus_addr", cap_addr, 32'h10);
        check32("lw_rdata", cap_rdata, 32'hDEAD_BEEF);

        run(1'b1, 1'b0, F3_B, 32'h13, 32'h0, 2, 32'h80FF_FF7F);
        check32("lb_rdata", cap_rdata, 32'hFFFF_FF80);
        run(1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 1, 32'h80FF_FF7F);
        check32("lbu_rdata", cap_rdata, 32'h0000_0080);
        run(1'b1, 1'b0, F3_H, 32'h12, 32'h0, 0, 32'h80FF_FF7F);
        check32("lh_rdata", cap_rdata, 32'hFFFF_80FF);
        run(1'b1, 1'b0, F3_HU, 32'h12, 32'h0, 0, 32'h80FF_FF7F);
        check32("lhu_rdata", cap_rdata, 32'h0000_80FF);

        run(1'b0, 1'b1, F3_B, 32'h21, 32'h0000_00AB, 0, 32'h0);
        check1("sb_we", cap_we, 1'b1);
        check32("sb_be", {28'h0, cap_be}, 32'h2);
        check32("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        check32("sb_addr", cap_addr, 32'h20);
        run(1'b0, 1'b1, F3_H, 32'h22, 32'h0000_1234, 1, 32'h0);
        check32("sh_be", {28'h0, cap_be}, 32'hC);
        check32("sh_wdata", cap_wdata, 32'h1234_1234);
        run(1'b0, 1'b1, F3_W, 32'h30, 32'hCAFE_F00D, 3, 32'h0);

        run(1'b1, 1'b0, F3_W, 32'h02, 32'h0, 0, 32'h0);
        check1("mis_fault", cap_fault, 1'b1);
        check32("mis_req_cycles", 32'(cap_req), 32'd0);
        check32("mis_stall_cycles", 32'(cap_stall), 32'd0);
        run(1'b1, 1'b1, F3_W, 32'h40, 32'h0, 0, 32'h0);
        check1("rdwr_fault", cap_fault, 1'b1);
        check32("rdwr_req_cycles", 32'(cap_req), 32'd0);
        run(1'b1, 1'b0, F3_HU, 32'h13, 32'h0, 0, 32'h0);
        check1("mis_h_fault", cap_fault, 1'b1);

        run(1'b1, 1'b0, F3_W, 32'h50, 32'h0, 99, 32'h1234_5678);
        check32("to_req_cycles", 32'(cap_req), 32'd15);
        check1("to_fault", cap_fault, 1'b1);
        check32("to_rdata", cap_rdata, 32'h0);
        run(1'b1, 1'b0, F3_W, 32'h54, 32'h0, 14, 32'h1234_5678);
        check32("edge_req_cycles", 32'(cap_req), 32'd15);
        check1("edge_fault", cap_fault, 1'b0);
        check32("edge_rdata", cap_rdata, 32'h1234_5678);

        // Asynchronous reset in the middle of an access.
        chk_en = 1'b0;
        @(posedge CLK); #1;
        mem_rd_en = 1'b1; mem_funct3 = F3_W; mem_addr = 32'h44; bus_ack = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check1("mid_req_before_rst", bus_req, 1'b1);
        RST = 1'b0;
        mem_rd_en = 1'b0;
        #1;
        check1("async_rst_req", bus_req, 1'b0);
        check1("async_rst_stall", stall, 1'b0);
        check32("async_rst_addr", bus_addr, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b1;
        e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_we = 1'b0; e_resp = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge CLK);

        run(1'b1, 1'b0, F3_W, 32'h0000_0060, 32'h0, 0, 32'hA5A5_0F0F);
        check32("post_rst_rdata", cap_rdata, 32'hA5A5_0F0F);
        check32("post_rst_stall_cycles", 32'(cap_stall), 32'd2);

        chk_en = 1'b0;
        @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
